alu_share_ctrl: RTL and testbench

Two-port arbiter and sequencer that shares the single-cycle 32-bit ALU between two requesters, e.g. the main datapath and an auxiliary address/fix-up unit. It accepts one operation at a time over a valid/ready request channel and round-robins between ports. It drives the ALU's operand and control inputs from registered copies of the request. It returns the registered ALU result to the originating port over a valid/ready response channel with backpressure.

---
 rtl/alu_share_if.sv | 45 ++++
 rtl/alu_share_ctrl.sv | 124 ++++++++++++
 tb/tb_alu_share_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_if.sv
// alu_share_if
// Bundles the two request channels and two response channels that share the ALU.
// Signal names carry the _i/_o suffix as seen from the arbiter (slave side).
//   req0_*/req1_*   : valid/ready request with op (3b), a, b (WIDTH)
//   resp0_*/resp1_* : valid/ready response with data (WIDTH)
// Handshake rule for every channel: a transfer happens on the rising edge
// where valid and ready are both high. A producer holds valid and payload
// stable until that transfer.
// Modports: slave (arbiter side), master (requester/environment side).
interface alu_share_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid_i;
    logic             req0_ready_o;
    logic [2:0]       req0_op_i;
    logic [WIDTH-1:0] req0_a_i;
    logic [WIDTH-1:0] req0_b_i;
    logic             req1_valid_i;
    logic             req1_ready_o;
    logic [2:0]       req1_op_i;
    logic [WIDTH-1:0] req1_a_i;
    logic [WIDTH-1:0] req1_b_i;
    logic             resp0_valid_o;
    logic             resp0_ready_i;
    logic [WIDTH-1:0] resp0_data_o;
    logic             resp1_valid_o;
    logic             resp1_ready_i;
    logic [WIDTH-1:0] resp1_data_o;

    modport slave (
        input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
        input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
        input  resp0_ready_i, resp1_ready_i,
        output req0_ready_o, req1_ready_o,
        output resp0_valid_o, resp0_data_o, resp1_valid_o, resp1_data_o
    );

    modport master (
        output req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
        output req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
        output resp0_ready_i, resp1_ready_i,
        input  req0_ready_o, req1_ready_o,
        input  resp0_valid_o, resp0_data_o, resp1_valid_o, resp1_data_o
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
// Shares one single-cycle ALU between two requesters. One operation is in
// flight at a time: IDLE (arbitrate/accept) -> EXEC (ALU driven) -> RESP
// (result returned with backpressure) -> IDLE.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   bus (slave)       : two request and two response valid/ready channels
//   alu_data1_o/2_o   : latched operands to the ALU
//   alu_ctrl_o        : latched ALU control code
//   alu_data_i        : combinational ALU result
//   busy_o            : high in EXEC or RESP
//   state_o           : current FSM state (debug observation)
// Optional build macro: ALU_SHARE_FIXED_PRIO_EN -- fixed priority (port 0
// wins ties) instead of round-robin; the last-grant pointer is then absent.
module alu_share_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    alu_share_if.slave       bus,
    output logic [WIDTH-1:0] alu_data1_o,
    output logic [WIDTH-1:0] alu_data2_o,
    output logic [2:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_data_i,
    output logic             busy_o,
    output logic [1:0]       state_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             port_q;
    logic [WIDTH-1:0] result_q;
    logic             grant0, grant1;
    logic             accept;
    logic             resp_ready;

`ifndef ALU_SHARE_FIXED_PRIO_EN
    // Port that won the most recent accepted request.
    logic last_q;
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef ALU_SHARE_FIXED_PRIO_EN
        grant0 = bus.req0_valid_i;
        grant1 = bus.req1_valid_i && !bus.req0_valid_i;
`else
        if (bus.req0_valid_i && bus.req1_valid_i) begin
            // Tie goes to the port that did not win last time.
            grant0 = last_q;
            grant1 = !last_q;
        end else begin
            grant0 = bus.req0_valid_i;
            grant1 = bus.req1_valid_i;
        end
`endif
    end

    // Ready is suppressed while reset is asserted so nothing is accepted then.
    assign accept = (state_q == IDLE) && !rst_i && (grant0 || grant1);
    assign resp_ready = port_q ? bus.resp1_ready_i : bus.resp0_ready_i;

    always_comb begin
        state_d = state_q;
        op_d    = grant1 ? bus.req1_op_i : bus.req0_op_i;
        a_d     = grant1 ? bus.req1_a_i  : bus.req0_a_i;
        b_d     = grant1 ? bus.req1_b_i  : bus.req0_b_i;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            port_q   <= 1'b0;
            result_q <= '0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= op_d;
                a_q    <= a_d;
                b_q    <= b_d;
                port_q <= grant1;
`ifndef ALU_SHARE_FIXED_PRIO_EN
                last_q <= grant1;
`endif
            end
            if (state_q == EXEC) begin
                result_q <= alu_data_i;
            end
        end
    end

    assign bus.req0_ready_o  = accept && grant0;
    assign bus.req1_ready_o  = accept && grant1;
    assign bus.resp0_valid_o = (state_q == RESP) && !port_q;
    assign bus.resp1_valid_o = (state_q == RESP) && port_q;
    assign bus.resp0_data_o  = result_q;
    assign bus.resp1_data_o  = result_q;

    assign alu_data1_o = a_q;
    assign alu_data2_o = b_q;
    assign alu_ctrl_o  = op_q;
    assign busy_o      = (state_q != IDLE);
    assign state_o     = state_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;
  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] alu_d1, alu_d2, alu_res;
  logic [2:0]   alu_ctrl;
  logic         busy;
  logic [1:0]   state_dbg;

  alu_share_if #(.WIDTH(W)) bus ();

  alu_share_ctrl #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .alu_data1_o(alu_d1),
    .alu_data2_o(alu_d2),
    .alu_ctrl_o (alu_ctrl),
    .alu_data_i (alu_res),
    .busy_o     (busy),
    .state_o    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ALU model (environment) ----------------
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      3'b000:  alu_res = alu_d1 & alu_d2;
      3'b001:  alu_res = alu_d1 ^ alu_d2;
      3'b010:  alu_res = alu_d1 << alu_d2[4:0];
      3'b011:  alu_res = alu_d1 + alu_d2;
      3'b100:  alu_res = alu_d1 - alu_d2;
      3'b101:  alu_res = alu_d1 * alu_d2;
      3'b110:  alu_res = alu_d1 + alu_d2;
      default: alu_res = $signed(alu_d1) >>> alu_d2[4:0];
    endcase
  end

  // ---------------- scoreboard ----------------
  // Entry = {port, data}
  logic [W:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a response transfers on the edge after a negedge where valid&ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.resp0_valid_o && bus.resp1_valid_o) begin
        check("both_resp_valid", 64'd1, 64'd0);
      end else if ((bus.resp0_valid_o && bus.resp0_ready_i) ||
                   (bus.resp1_valid_o && bus.resp1_ready_i)) begin
        logic [W:0] got, e;
        got = bus.resp1_valid_o ? {1'b1, bus.resp1_data_o} : {1'b0, bus.resp0_data_o};
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {31'd0, got}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_port_data", {31'd0, got}, {31'd0, e});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int port, input logic v, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (port == 0) begin
      bus.req0_valid_i = v; bus.req0_op_i = op; bus.req0_a_i = a; bus.req0_b_i = b;
    end else begin
      bus.req1_valid_i = v; bus.req1_op_i = op; bus.req1_a_i = a; bus.req1_b_i = b;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input int port, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_data, input bit push);
    bit got;
    got = 0;
    set_req(port, 1'b1, op, a, b);
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if ((port == 0) ? bus.req0_ready_o : bus.req1_ready_o) got = 1;
    end
    if (!got) check("issue_timeout", 64'd0, 64'd1);
    else if (push) exp_q.push_back({port[0], exp_data});
    @(posedge clk); #1;
    set_req(port, 1'b0, 3'b000, '0, '0);
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1;
    end
    if (!done) check("drain_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {alu_d1, alu_d2}, 64'd0);
    check({name, "_misc"},
          {56'd0, alu_ctrl, bus.req0_ready_o, bus.req1_ready_o,
           bus.resp0_valid_o, bus.resp1_valid_o, busy}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  int grants[$];

  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, 3'b000, '0, '0);
    set_req(1, 1'b0, 3'b000, '0, '0);
    bus.resp0_ready_i = 1'b1;
    bus.resp1_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk); #1;

    // Single ADD on port 0 with latency / EXEC checks.
    issue(0, 3'b011, 32'd5, 32'd7, 32'd12, 1);
    @(negedge clk);
    check("exec_alu_ctrl", {61'd0, alu_ctrl}, 64'd3);
    check("exec_alu_ops", {alu_d1, alu_d2}, {32'd5, 32'd7});
    check("exec_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("add_resp_valid", {62'd0, bus.resp0_valid_o, bus.resp1_valid_o}, 64'b10);
    wait_drain();

    // Signed SRAI and SUB on port 1, plus a few other ops.
    issue(1, 3'b111, 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
    wait_drain();
    issue(1, 3'b100, 32'd3, 32'd5, 32'hFFFF_FFFE, 1);
    wait_drain();
    issue(0, 3'b010, 32'd3, 32'd4, 32'h0000_0030, 1);
    wait_drain();
    issue(1, 3'b110, 32'h10, 32'hFFFF_FFFF, 32'h0000_000F, 1);
    wait_drain();

    // Response backpressure: XOR on port 0, port 1 waiting meanwhile.
    bus.resp0_ready_i = 1'b0;
    issue(0, 3'b001, 32'hFF, 32'h0F, 32'hF0, 1);
    set_req(1, 1'b1, 3'b000, 32'hFF, 32'h0F);
    @(negedge clk);   // EXEC
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", {62'd0, bus.resp0_valid_o, bus.resp1_valid_o}, 64'b10);
      check("bp_data", {32'd0, bus.resp0_data_o}, 64'hF0);
      check("bp_ready_busy", {61'd0, bus.req0_ready_o, bus.req1_ready_o, busy}, 64'b001);
    end
    @(posedge clk); #1;
    bus.resp0_ready_i = 1'b1;
    exp_q.push_back({1'b1, 32'h0000_000F});
    @(negedge clk);   // monitor consumes 0xF0 here
    @(negedge clk);
    check("bp_release_idle", {62'd0, busy, bus.req1_ready_o}, 64'b01);
    @(posedge clk); #1;
    set_req(1, 1'b0, 3'b000, '0, '0);
    wait_drain();

    // Reset during EXEC of port 0 SLL: transaction dropped.
    issue(0, 3'b010, 32'd1, 32'd4, 32'd16, 0);
    check("sll_in_exec", {62'd0, state_dbg}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_mid_reset");
    repeat (4) @(negedge clk);
    check("no_resp_after_reset", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;

    // Tie-breaking: both ports valid continuously.
`ifdef ALU_SHARE_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 32'd2});
`else
    exp_q.push_back({1'b0, 32'd2});
    exp_q.push_back({1'b1, 32'd12});
    exp_q.push_back({1'b0, 32'd2});
    exp_q.push_back({1'b1, 32'd12});
`endif
    set_req(0, 1'b1, 3'b011, 32'd1, 32'd1);
    set_req(1, 1'b1, 3'b101, 32'd3, 32'd4);
    for (int n = 0; n < 60 && grants.size() < 4; n++) begin
      @(negedge clk);
      if (bus.req0_ready_o) grants.push_back(0);
      if (bus.req1_ready_o) grants.push_back(1);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'b000, '0, '0);
    set_req(1, 1'b0, 3'b000, '0, '0);
    check("tie_grant_count", grants.size(), 64'd4);
    for (int i = 0; i < grants.size() && i < 4; i++) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
      check("tie_grant_order", grants[i], 64'd0);
`else
      check("tie_grant_order", grants[i], (i % 2 == 0) ? 64'd0 : 64'd1);
`endif
    end
    wait_drain();

    check("queue_empty", exp_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
